// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// default program-space geometry.
package fetch_unit_pkg;

   localparam int unsigned PC_W_DEFAULT     = 16;
   localparam int unsigned CNT_W_DEFAULT    = 16;
   localparam int unsigned PROG_MAX_DEFAULT = 32'h0000_07FF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: steps the program counter through the ROM,
// follows decoder jumps, and stops on halt or on leaving the legal range.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] PROG_MAX = PC_W'(PROG_MAX_DEFAULT),
   parameter int unsigned     CNT_W    = CNT_W_DEFAULT
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [PC_W-1:0]   StartAddr,
   input  logic              jump_en,
   input  logic [PC_W-1:0]   Target,
   input  logic              Halt,
   output logic [PC_W-1:0]   ProgCtr,
   output logic              Running,
   output logic              Done,
   output logic              Fault,
   output logic [CNT_W-1:0]  CycleCount
);

   fetch_state_t     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic             running_q, done_q;

   // Next-state and datapath decode
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               state_d = ST_RUN;
               pc_d    = StartAddr;
               cnt_d   = '0;
               fault_d = 1'b0;
            end
         end

         ST_RUN: begin
            // The exit cycle is still a RUN cycle, so count before deciding.
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end

            if (Halt) begin
               state_d = ST_DONE;
            end else if (jump_en) begin
               if (Target > PROG_MAX) begin
                  state_d = ST_DONE;
                  fault_d = 1'b1;
               end else begin
                  pc_d = Target;
               end
            end else if (pc_q < PROG_MAX) begin
               pc_d = pc_q + PC_W'(1);
            end else begin
               // Falling off the end of program space is a fault, never a wrap.
               state_d = ST_DONE;
               fault_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         fault_q   <= 1'b0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         fault_q   <= fault_d;
         running_q <= (state_d == ST_RUN);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign ProgCtr    = pc_q;
   assign CycleCount = cnt_q;
   assign Running    = running_q;
   assign Done       = done_q;
   assign Fault      = fault_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

   localparam int unsigned PC_W   = 16;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PMAX   = 32'h07FF;

   logic              Clk;
   logic              Reset;
   logic              Start;
   logic [PC_W-1:0]   StartAddr;
   logic              jump_en;
   logic [PC_W-1:0]   Target;
   logic              Halt;
   logic [PC_W-1:0]   ProgCtr;
   logic              Running;
   logic              Done;
   logic              Fault;
   logic [CNT_W-1:0]  CycleCount;

   logic [PC_W-1:0]   pc4;
   logic              running4, done4, fault4;
   logic [3:0]        cnt4;

   int unsigned n_vec;
   int unsigned n_err;

   // Behavioural model: where the program is and how long it has run.
   int unsigned m_pc;
   int unsigned m_cnt;
   bit          m_run, m_done, m_fault;

   fetch_unit dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .StartAddr  (StartAddr),
      .jump_en    (jump_en),
      .Target     (Target),
      .Halt       (Halt),
      .ProgCtr    (ProgCtr),
      .Running    (Running),
      .Done       (Done),
      .Fault      (Fault),
      .CycleCount (CycleCount)
   );

   fetch_unit #(.CNT_W(4)) dut4 (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .StartAddr  (StartAddr),
      .jump_en    (jump_en),
      .Target     (Target),
      .Halt       (Halt),
      .ProgCtr    (pc4),
      .Running    (running4),
      .Done       (done4),
      .Fault      (fault4),
      .CycleCount (cnt4)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (Reset) begin
         m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_fault = 0;
      end else if (!m_run) begin
         if (Start) begin
            m_pc = int'(StartAddr); m_cnt = 0; m_run = 1; m_done = 0; m_fault = 0;
         end
      end else begin
         m_cnt = m_cnt + 1;
         if (Halt) begin
            m_run = 0; m_done = 1;
         end else if (jump_en && int'(Target) > int'(PMAX)) begin
            m_run = 0; m_done = 1; m_fault = 1;
         end else if (jump_en) begin
            m_pc = int'(Target);
         end else if (m_pc < PMAX) begin
            m_pc = m_pc + 1;
         end else begin
            m_run = 0; m_done = 1; m_fault = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("pc",      32'(ProgCtr),    m_pc);
      chk("running", 32'(Running),    32'(m_run));
      chk("done",    32'(Done),       32'(m_done));
      chk("fault",   32'(Fault),      32'(m_fault));
      chk("cnt",     32'(CycleCount), (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk("cnt4",    32'(cnt4),       (m_cnt > 15) ? 32'd15 : m_cnt);
      chk("pc4",     32'(pc4),        m_pc);
   endtask

   // One clock: model follows the inputs held across the edge, then compare.
   task automatic step();
      @(posedge Clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic quiet();
      Reset = 1'b0; Start = 1'b0; jump_en = 1'b0; Halt = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0; m_fault = 0;
      quiet();
      StartAddr = '0; Target = '0;

      Reset = 1'b1;
      step(); step();
      chk("rst_pc", 32'(ProgCtr), 32'h0);
      Reset = 1'b0;
      step();

      // Start from 0x0003 and free-run
      Start = 1'b1; StartAddr = 16'h0003;
      step();
      chk("start_pc", 32'(ProgCtr), 32'h3);
      chk("start_run", 32'(Running), 32'h1);
      Start = 1'b0;
      step();
      chk("inc_pc", 32'(ProgCtr), 32'h4);
      chk("inc_cnt", 32'(CycleCount), 32'h1);
      step();

      // Jumps, then halt overriding a jump
      jump_en = 1'b1; Target = 16'h0010; step();
      Target = 16'h01F7; step();
      chk("jump_pc", 32'(ProgCtr), 32'h1F7);
      Target = 16'h0020; step();
      Halt = 1'b1; Target = 16'h0050; step();
      chk("halt_done", 32'(Done), 32'h1);
      chk("halt_pc", 32'(ProgCtr), 32'h20);
      chk("halt_fault", 32'(Fault), 32'h0);
      quiet();

      // Run off the end of program space
      Start = 1'b1; StartAddr = 16'h0100; step();
      Start = 1'b0; jump_en = 1'b1; Target = 16'h0445; step();
      jump_en = 1'b0;
      repeat (PMAX - 32'h445) step();
      chk("end_pc", 32'(ProgCtr), 32'h7FF);
      step();
      chk("end_fault", 32'(Fault), 32'h1);
      chk("end_pc_hold", 32'(ProgCtr), 32'h7FF);
      step();

      // Jump beyond the legal range
      Start = 1'b1; StartAddr = 16'h0010; step();
      Start = 1'b0; jump_en = 1'b1; Target = 16'h0800; step();
      chk("oob_fault", 32'(Fault), 32'h1);
      chk("oob_pc", 32'(ProgCtr), 32'h10);
      jump_en = 1'b0;

      // Start ignored in RUN; restart from DONE
      Start = 1'b1; StartAddr = 16'h0200; step();
      Start = 1'b0; step();
      Start = 1'b1; StartAddr = 16'h0300; step();
      chk("start_in_run", 32'(ProgCtr), 32'h202);
      Start = 1'b0; Halt = 1'b1; step();
      Halt = 1'b0; Start = 1'b1; StartAddr = 16'h0201; step();
      chk("restart_done", 32'(Done), 32'h0);
      chk("restart_pc", 32'(ProgCtr), 32'h201);
      Start = 1'b0; step();
      chk("restart_cnt", 32'(CycleCount), 32'h1);

      // Reset wins over start and jump mid-run
      jump_en = 1'b1; Target = 16'h0456; step();
      Reset = 1'b1; Start = 1'b1; step();
      chk("rst_run_pc", 32'(ProgCtr), 32'h0);
      chk("rst_run_cnt", 32'(CycleCount), 32'h0);
      quiet();

      // Narrow counter saturation
      Start = 1'b1; StartAddr = 16'h0000; step();
      Start = 1'b0;
      repeat (20) step();
      chk("sat4", 32'(cnt4), 32'hF);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         Reset     = ($urandom_range(0, 63) == 0);
         Start     = ($urandom_range(0, 15) == 0);
         Halt      = ($urandom_range(0, 63) == 0);
         jump_en   = ($urandom_range(0, 7) == 0);
         Target    = PC_W'($urandom_range(0, 32'h0900));
         StartAddr = PC_W'($urandom_range(0, 32'h0810));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fetch_unit
